// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 core widths and call-stack instantiation defaults
package chip8_pkg;
  localparam int PC_W = 12;
  localparam int STACK_W = 16;
  localparam int STACK_DEPTH = 16;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x WIDTH storage; in clk/we/waddr/wdata/raddr_a/raddr_b, out rdata_a/rdata_b (async reads)
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/call_stack.sv
// call_stack: CALL/RET LIFO; in clk/rst/push/pop/flush/err_clr/data_in, out top/count/empty/full/overflow/underflow
module call_stack
  import chip8_pkg::*;
#(
  parameter int WIDTH = STACK_W,
  parameter int DEPTH = STACK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} op_e;
  op_e op;
  logic we, ovf_set, unf_set;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] rd_top, rd_below;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign op = flush ? OP_NONE : push && pop ? OP_REPL : push ? OP_PUSH : pop ? OP_POP : OP_NONE;
  assign we = op == OP_REPL || (op == OP_PUSH && !full);
  assign waddr = op == OP_REPL && !empty ? AW'(count - CNT_W'(1)) : AW'(count);
  assign ovf_set = op == OP_PUSH && full;
  assign unf_set = (op == OP_POP || op == OP_REPL) && empty;
  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(data_in),
    .raddr_a(AW'(count - CNT_W'(1))),
    .raddr_b(AW'(count - CNT_W'(2))),
    .rdata_a(rd_top),
    .rdata_b(rd_below)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      top <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= ovf_set || (overflow && !err_clr);
      underflow <= unf_set || (underflow && !err_clr);
      if (flush) begin
        count <= '0;
        top <= '0;
      end else if (op == OP_REPL) begin
        top <= data_in;
        if (empty) count <= CNT_W'(1);
      end else if (op == OP_PUSH && !full) begin
        top <= data_in;
        count <= count + CNT_W'(1);
      end else if (op == OP_POP && !empty) begin
        count <= count - CNT_W'(1);
        top <= count == CNT_W'(1) ? '0 : rd_below;
      end
    end
  a_top_matches_ram: assert property (@(posedge clk) disable iff (rst) !empty |-> top == rd_top);
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed and randomised checks of call_stack against a queue model
module tb_call_stack;
  localparam int D = 16;
  logic clk = 0, rst = 1, push = 0, pop = 0, flush = 0, err_clr = 0;
  logic [15:0] data_in = '0, top;
  logic [4:0] count;
  logic empty, full, overflow, underflow;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  logic mo = 0, mu = 0;
  call_stack dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
    .data_in(data_in), .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic p, o, f, e, input logic [15:0] d);
    logic so = 0, su = 0;
    if (f) q.delete();
    else if (p && o) begin
      if (q.size() == 0) begin
        su = 1;
        q.push_back(int'(d));
      end else q[$] = int'(d);
    end else if (p) begin
      if (q.size() == D) so = 1;
      else q.push_back(int'(d));
    end else if (o) begin
      if (q.size() == 0) su = 1;
      else void'(q.pop_back());
    end
    mo = so | (mo & ~e);
    mu = su | (mu & ~e);
  endtask
  task automatic step(input logic p, o, f, e, input logic [15:0] d);
    @(negedge clk);
    push = p; pop = o; flush = f; err_clr = e; data_in = d;
    @(posedge clk);
    model(p, o, f, e, d);
    #1;
    push = 0; pop = 0; flush = 0; err_clr = 0;
  endtask
  task automatic mcheck(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_top"}, 32'(top), q.size() ? 32'(q[$]) : 0);
    chk({tag, "_ovf"}, 32'(overflow), 32'(mo));
    chk({tag, "_unf"}, 32'(underflow), 32'(mu));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_top", 32'(top), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);
    step(1, 0, 0, 0, 16'h0202);
    step(1, 0, 0, 0, 16'h0304);
    step(1, 0, 0, 0, 16'h0406);
    chk("push3_count", 32'(count), 3);
    chk("push3_top", 32'(top), 32'h0406);
    step(0, 1, 0, 0, 0);
    chk("pop1_top", 32'(top), 32'h0304);
    step(0, 1, 0, 0, 0);
    chk("pop2_top", 32'(top), 32'h0202);
    step(0, 1, 0, 0, 0);
    chk("pop3_top", 32'(top), 0);
    chk("pop3_empty", 32'(empty), 1);
    chk("pop3_unf", 32'(underflow), 0);
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 16'(16'h100 + i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_ovf", 32'(overflow), 0);
    step(1, 0, 0, 0, 16'hBEEF);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_top", 32'(top), 32'h10F);
    step(0, 1, 0, 0, 0);
    chk("ovf_pop_top", 32'(top), 32'h10E);
    chk("ovf_pop_full", 32'(full), 0);
    step(0, 0, 0, 1, 0);
    chk("errclr_ovf", 32'(overflow), 0);
    for (int i = 0; i < D - 1; i++) step(0, 1, 0, 0, 0);
    chk("drain_empty", 32'(empty), 1);
    step(0, 1, 0, 0, 0);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    step(1, 1, 0, 0, 16'h0ABC);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_top", 32'(top), 32'hABC);
    chk("pp_empty_unf", 32'(underflow), 1);
    step(0, 1, 0, 1, 0);
    chk("pop_clr_unf", 32'(underflow), 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 16'(16'h500 + i));
    step(1, 1, 0, 0, 16'h0777);
    chk("repl_count", 32'(count), 5);
    chk("repl_top", 32'(top), 32'h777);
    step(0, 1, 0, 0, 0);
    chk("repl_pop_top", 32'(top), 32'h504);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 16'(16'h600 + i));
    step(1, 1, 0, 0, 16'h0888);
    chk("repl_full_count", 32'(count), 16);
    chk("repl_full_top", 32'(top), 32'h888);
    chk("repl_full_ovf", 32'(overflow), 0);
    step(0, 0, 1, 0, 0);
    chk("flush_count", 32'(count), 0);
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 16'(16'h700 + i));
    step(1, 0, 0, 0, 16'h1234);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    chk("pre_flush_count", 32'(count), 4);
    chk("pre_flush_ovf", 32'(overflow), 1);
    step(1, 0, 1, 0, 16'h4321);
    chk("flushpush_count", 32'(count), 0);
    chk("flushpush_top", 32'(top), 0);
    chk("flushpush_ovf", 32'(overflow), 1);
    mcheck("model_sync");
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
           $urandom_range(0, 15) == 0, 16'($urandom));
      mcheck("rand");
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 16'(16'h900 + i));
    @(negedge clk);
    push = 1; data_in = 16'hDEAD;
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_top", 32'(top), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_flags", {30'd0, overflow, underflow}, 0);
    push = 0;
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0, 0);
    chk("post_rst_count", 32'(count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
